// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen
// Two-flop synchronizer, four-state debounce FSM, registered level and one-shot
// press strobe for a downstream counter enable.
// Optional build macro: DEBOUNCE_AUTO_REPEAT_EN adds a hold-to-repeat strobe
// every REPEAT_CYCLES cycles while the debounced level stays high.
//
// Handshake: none. btn_in is an unqualified asynchronous level; pulse_out is a
// single-cycle strobe with no back-pressure, so the consumer must sample it
// every cycle.
module debounce_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 5,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic pulse_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARM_HI = 2'd1;
  localparam logic [1:0] HIGH   = 2'd2;
  localparam logic [1:0] ARM_LO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rep_fire;

  assign s = sync2;

  // Two-flop synchronizer; only its output is ever seen by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep;

  // A repeat strobe fires only while the level stays high this edge.
  assign rep_fire = (state == HIGH) && s && (rep == REP_LAST);

  // Repeat timer runs only in HIGH and restarts at 0 on any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep <= '0;
    end else if (state == HIGH && s) begin
      if (rep == REP_LAST) rep <= '0;
      else                 rep <= rep + 1'b1;
    end else begin
      rep <= '0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounce FSM: a new level must hold for DEBOUNCE_CYCLES synchronized
  // cycles; any toggle while arming falls back to the last stable state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ARM_HI;
            cnt   <= '0;
          end
        end
        ARM_HI: begin
          if (!s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state     <= HIGH;
            level_out <= 1'b1;
            pulse_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= ARM_LO;
            cnt   <= '0;
          end else if (rep_fire) begin
            pulse_out <= 1'b1;
          end
        end
        ARM_LO: begin
          if (s) begin
            state <= HIGH;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            level_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
